// File: rtl/mod_counter_pkg.sv
// Shared types, constants and helpers for the modulo timekeeping counter family.
package mod_counter_pkg;

    // Count direction as sampled from up_dn.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Moduli for a seconds -> minutes -> hours chain.
    localparam int unsigned SEC_MODULUS = 60;
    localparam int unsigned MIN_MODULUS = 60;
    localparam int unsigned HR_MODULUS  = 24;

    // $clog2 that never yields a zero-width vector.
    function automatic int unsigned clog2_safe(input int unsigned value);
        return (value <= 1) ? 1 : int'($clog2(value));
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Prescaler: emits step on every PRESCALE-th enabled cycle.
// With PRESCALE=1 the counter is a constant 0 and step follows en directly.
module mod_counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int unsigned      PreW    = clog2_safe(PRESCALE);
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_d, pre_q;

    assign step = en && (pre_q == PreLast);

    // Next prescaler value: clear wins, otherwise advance on en and wrap on step.
    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = step ? '0 : pre_q + PreW'(1);
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with prescaler, sync clear/load, combinational cascade
// carry and registered wrap tick.
// Optional macro MOD_COUNTER_BCD_EN adds registered BCD digit outputs (MODULUS <= 100).
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned MODULUS  = SEC_MODULUS,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             tick
`ifdef MOD_COUNTER_BCD_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`endif
);

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

    dir_e             dir;
    logic             step;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] load_sat;
    logic [WIDTH-1:0] count_d, count_q;
    logic             tick_d, tick_q;

    assign dir = dir_e'(up_dn);

    mod_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clear | load),
        .step    (step)
    );

    // Terminal value, saturated load value and cascade carry.
    always_comb begin
        terminal  = (dir == DIR_UP) ? MaxCount : '0;
        load_sat  = (load_val > MaxCount) ? MaxCount : load_val;
        carry_out = step && (count_q == terminal) && !clear && !load;
    end

    // Count next state: clear > load > step > hold.
    always_comb begin
        count_d = count_q;
        tick_d  = carry_out;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_sat;
        end else if (step) begin
            if (dir == DIR_UP) begin
                count_d = (count_q == MaxCount) ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = (count_q == '0) ? MaxCount : count_q - WIDTH'(1);
            end
        end
    end

    // Count and tick registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;

`ifdef MOD_COUNTER_BCD_EN
    // Binary to packed {tens, ones}; only valid for values below 100.
    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 32'(v);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    localparam logic [7:0] MaxBcd = to_bcd(MaxCount);

    logic [7:0] bcd_d, bcd_q;

    // BCD digits mirror every count update incrementally.
    always_comb begin
        bcd_d = bcd_q;
        if (clear) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d = to_bcd(load_sat);
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (count_q == MaxCount) begin
                    bcd_d = '0;
                end else if (bcd_q[3:0] == 4'd9) begin
                    bcd_d = {bcd_q[7:4] + 4'd1, 4'd0};
                end else begin
                    bcd_d = {bcd_q[7:4], bcd_q[3:0] + 4'd1};
                end
            end else begin
                if (count_q == '0) begin
                    bcd_d = MaxBcd;
                end else if (bcd_q[3:0] == 4'd0) begin
                    bcd_d = {bcd_q[7:4] - 4'd1, 4'd9};
                end else begin
                    bcd_d = {bcd_q[7:4], bcd_q[3:0] - 4'd1};
                end
            end
        end
    end

    // BCD digit register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_tens = bcd_q[7:4];
    assign bcd_ones = bcd_q[3:0];
`else
    // Binary count only; no BCD state.
`endif

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised modulo-N timekeeping counter with prescaler, up/down mode, synchronous clear/load, a combinational cascade carry and a registered wrap tick.
- Next-generation building block for the clock/timer chain (seconds → minutes → hours).
- Instances cascade by feeding one stage's carry_out into the next stage's en.

Parameters:
- WIDTH, 7, count register width in bits; must satisfy MODULUS <= 2**WIDTH.
- MODULUS, 60, count sequence length; count range is 0..MODULUS-1; MODULUS >= 2.
- PRESCALE, 1, number of enabled cycles per count step; 1 means a step on every enabled cycle; PRESCALE >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; the prescaler advances only when en=1.
- up_dn  in  1  direction: 1 counts up, 0 counts down; sampled on every step.
- clear  in  1  synchronous clear.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- carry_out  out  1  combinational; 1 when a step occurs this cycle AND count is at its terminal value.
- tick  out  1  registered; carry_out delayed by one cycle.

Behaviour:
- Reset (reset_n=0, asynchronous): count=0, prescaler=0, tick=0. Outputs hold these values until the first clk edge after reset_n deasserts.
- Precedence, per clk edge: clear > load > step > hold.
- step = en && (prescaler == PRESCALE-1). When PRESCALE=1, step = en.
- Prescaler:
  - Increments on each en=1 cycle and wraps to 0 on step.
  - Holds its value when en=0.
  - Cleared to 0 by clear or load.
- clear: count<=0, prescaler<=0, tick<=0. carry_out is forced to 0 in that cycle.
- load:
  - count<=load_val when load_val < MODULUS; otherwise count<=MODULUS-1 (saturate).
  - tick<=0; carry_out is forced to 0 in that cycle.
- Step, up mode: count<=count+1, wrapping MODULUS-1 → 0. Terminal value = MODULUS-1.
- Step, down mode: count<=count-1, wrapping 0 → MODULUS-1. Terminal value = 0.
- carry_out = step && (count == terminal) && !clear && !load. It is combinational so cascaded stages step in the same edge.
- tick <= carry_out on every edge: a one-cycle pulse in the cycle where count shows the wrapped value.
- A direction change takes effect on the next step only; there is no glitch on count.
- Arithmetic:
  - Internal compares are done at WIDTH bits.
  - No out-of-range count value is ever reachable; the load saturation above guarantees this.
- Reset asserted mid-prescale: all state returns to zero immediately; no tick is issued.

Optional Feature:
- Macro: MOD_COUNTER_BCD_EN.
- With the macro defined:
  - Adds outputs bcd_tens[3:0] and bcd_ones[3:0], registered, reflecting count after the same edge.
  - Tracked incrementally alongside count: digit carry/borrow, wrap, clear and load all mirrored.
  - load updates both digits via a binary-to-BCD conversion.
  - Requires MODULUS <= 100.
  - Both digits reset to 0.
- Without the macro: the ports are absent and no BCD logic is generated.

Decomposition:
- Package mod_counter_pkg:
  - dir_e enum (DIR_DOWN=0, DIR_UP=1).
  - Function clog2_safe.
  - Constants SEC_MODULUS=60, MIN_MODULUS=60, HR_MODULUS=24 for chain instantiation.
- Sub-module mod_counter_prescaler (parameter PRESCALE; ports clk, reset_n, en, clr, step). It is the natural split; the modulo core stays in mod_counter.

Test Plan:
- Default params, up, en=1 for 62 cycles from reset: count goes 0..59 then 0,1. carry_out is high only while count=59. tick is high only in the cycle count=0 after the wrap.
- up_dn=0 from reset: the first step gives count=59 and carry_out=1 while count=0, with tick on the next cycle. Then 58, 57 on consecutive steps.
- PRESCALE=4, en toggled 1,0,1,1,1: count increments only after the fourth en=1 cycle; the prescaler holds during en=0.
- load=1 with load_val=75, MODULUS=60 → count=59. In the same cycle, clear=1 with load=1 → count=0, carry_out=0.
- Cascade seconds→minutes (both MODULUS=60), en=1 for 3600 steps: minutes reaches 59 then wraps to 0 at step 3600. The minutes count changes exactly on the seconds 59→0 edge.
- reset_n pulsed low between edges at count=37, prescaler mid-count: count=0 and tick=0 immediately, asynchronously. With MOD_COUNTER_BCD_EN defined, bcd_tens/bcd_ones track count (37 → 3/7, then 0/0 after reset).
